// File: rtl/mips_pkg.sv
// Shared definitions for the five-stage MIPS-subset core: opcode/funct
// encodings, the ALU operation enum, the decoded control bundle carried down
// the pipeline, and the NOP instruction word.
package mips_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  localparam logic [31:0] NopInstr = 32'h0000_0000;

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluSlt
  } alu_op_e;

  // Decoded control that travels with an instruction through ID/EX and EX/MEM.
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       use_imm;
    alu_op_e    alu_op;
    logic [4:0] dest;
  } ctrl_t;

  localparam ctrl_t CtrlNop = '{
    reg_write: 1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    use_imm:   1'b0,
    alu_op:    AluAdd,
    dest:      5'd0
  };

  function automatic logic [31:0] sign_ext16(logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one write port written
// at the rising edge. r0 always reads zero and ignores writes. A read of the
// register being written in the same cycle returns the incoming value.
//   clk_i, rst_i         clock, asynchronous active-high reset (clears all)
//   raddr_a_i/rdata_a_o  read port A
//   raddr_b_i/rdata_b_o  read port B
//   we_i, waddr_i, wdata_i  write port
module mips_regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_b_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'h0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    if (raddr_a_i == 5'd0) begin
      rdata_a_o = 32'h0;
    end else if (we_i && (waddr_i == raddr_a_i)) begin
      rdata_a_o = wdata_i;
    end
  end

  always_comb begin
    rdata_b_o = regs_q[raddr_b_i];
    if (raddr_b_i == 5'd0) begin
      rdata_b_o = 32'h0;
    end else if (we_i && (waddr_i == raddr_b_i)) begin
      rdata_b_o = wdata_i;
    end
  end

endmodule

// File: rtl/mips_cpu.sv
// Five-stage pipelined MIPS-subset core (IF, ID, EX, MEM, WB) with a read-only
// program bus and a single-port data bus. No branches, stalls or forwarding;
// software spaces dependent instructions at least three apart.
//   CLK, reset      clock, asynchronous active-high reset
//   Prog_BUS_READ   instruction word at ADDR_Prog
//   ADDR_Prog, CS_P program word address (PC) and chip select
//   Data_BUS_READ   load data
//   ADDR            data byte address
//   Data_BUS_WRITE  store data
//   CS, WE          data chip select and write enable
module mips_cpu
  import mips_pkg::*;
(
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] Prog_BUS_READ,
  output logic [31:0] ADDR_Prog,
  output logic        CS_P,
  input  logic [31:0] Data_BUS_READ,
  output logic [31:0] ADDR,
  output logic [31:0] Data_BUS_WRITE,
  output logic        CS,
  output logic        WE
);

  // ---------------------------------------------------------------- IF
  logic        fetch_en_q;
  logic [31:0] pc_q;
  logic [31:0] ifid_instr_q;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      fetch_en_q   <= 1'b0;
      pc_q         <= 32'h0;
      ifid_instr_q <= NopInstr;
    end else begin
      fetch_en_q <= 1'b1;
      if (fetch_en_q) begin
        ifid_instr_q <= Prog_BUS_READ;
        pc_q         <= pc_q + 32'd1;
      end else begin
        ifid_instr_q <= NopInstr;
      end
    end
  end

  assign ADDR_Prog = pc_q;
  assign CS_P      = fetch_en_q;

  // ---------------------------------------------------------------- ID
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [31:0] id_rs_val;
  logic [31:0] id_rt_val;
  ctrl_t       id_ctrl;

  assign id_opcode = ifid_instr_q[31:26];
  assign id_rs     = ifid_instr_q[25:21];
  assign id_rt     = ifid_instr_q[20:16];
  assign id_rd     = ifid_instr_q[15:11];
  assign id_funct  = ifid_instr_q[5:0];

  // Shift amount field has no use in this subset.
  logic unused_shamt;
  assign unused_shamt = ^ifid_instr_q[10:6];

  always_comb begin
    id_ctrl = CtrlNop;
    case (id_opcode)
      OpRtype: begin
        id_ctrl.dest      = id_rd;
        id_ctrl.reg_write = 1'b1;
        case (id_funct)
          FnAdd:   id_ctrl.alu_op = AluAdd;
          FnSub:   id_ctrl.alu_op = AluSub;
          FnAnd:   id_ctrl.alu_op = AluAnd;
          FnOr:    id_ctrl.alu_op = AluOr;
          FnSlt:   id_ctrl.alu_op = AluSlt;
          default: id_ctrl = CtrlNop;
        endcase
      end
      OpAddi: begin
        id_ctrl.reg_write = 1'b1;
        id_ctrl.use_imm   = 1'b1;
        id_ctrl.dest      = id_rt;
      end
      OpLw: begin
        id_ctrl.reg_write = 1'b1;
        id_ctrl.mem_read  = 1'b1;
        id_ctrl.use_imm   = 1'b1;
        id_ctrl.dest      = id_rt;
      end
      OpSw: begin
        id_ctrl.mem_write = 1'b1;
        id_ctrl.use_imm   = 1'b1;
      end
      default: id_ctrl = CtrlNop;
    endcase
  end

  logic        wb_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;

  mips_regfile u_regfile (
    .clk_i     (CLK),
    .rst_i     (reset),
    .raddr_a_i (id_rs),
    .rdata_a_o (id_rs_val),
    .raddr_b_i (id_rt),
    .rdata_b_o (id_rt_val),
    .we_i      (wb_we),
    .waddr_i   (wb_dest),
    .wdata_i   (wb_data)
  );

  ctrl_t       idex_ctrl_q;
  logic [31:0] idex_rs_val_q;
  logic [31:0] idex_rt_val_q;
  logic [31:0] idex_imm_q;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      idex_ctrl_q   <= CtrlNop;
      idex_rs_val_q <= 32'h0;
      idex_rt_val_q <= 32'h0;
      idex_imm_q    <= 32'h0;
    end else begin
      idex_ctrl_q   <= id_ctrl;
      idex_rs_val_q <= id_rs_val;
      idex_rt_val_q <= id_rt_val;
      idex_imm_q    <= sign_ext16(ifid_instr_q[15:0]);
    end
  end

  // ---------------------------------------------------------------- EX
  logic [31:0] alu_b;
  logic [31:0] alu_result;

  always_comb begin
    alu_b      = idex_ctrl_q.use_imm ? idex_imm_q : idex_rt_val_q;
    alu_result = 32'h0;
    case (idex_ctrl_q.alu_op)
      AluAdd:  alu_result = idex_rs_val_q + alu_b;
      AluSub:  alu_result = idex_rs_val_q - alu_b;
      AluAnd:  alu_result = idex_rs_val_q & alu_b;
      AluOr:   alu_result = idex_rs_val_q | alu_b;
      AluSlt:  alu_result = {31'b0, $signed(idex_rs_val_q) < $signed(alu_b)};
      default: alu_result = 32'h0;
    endcase
  end

  ctrl_t       exmem_ctrl_q;
  logic [31:0] exmem_alu_q;
  logic [31:0] exmem_rt_val_q;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      exmem_ctrl_q   <= CtrlNop;
      exmem_alu_q    <= 32'h0;
      exmem_rt_val_q <= 32'h0;
    end else begin
      exmem_ctrl_q   <= idex_ctrl_q;
      exmem_alu_q    <= alu_result;
      exmem_rt_val_q <= idex_rt_val_q;
    end
  end

  // ---------------------------------------------------------------- MEM
  // Bus strobes come straight from flops so an asynchronous reset drops them
  // immediately, even mid-store.
  assign ADDR           = exmem_alu_q;
  assign Data_BUS_WRITE = exmem_rt_val_q;
  assign CS             = exmem_ctrl_q.mem_read | exmem_ctrl_q.mem_write;
  assign WE             = exmem_ctrl_q.mem_write;

  logic        memwb_we_q;
  logic [4:0]  memwb_dest_q;
  logic [31:0] memwb_result_q;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      memwb_we_q     <= 1'b0;
      memwb_dest_q   <= 5'd0;
      memwb_result_q <= 32'h0;
    end else begin
      memwb_we_q     <= exmem_ctrl_q.reg_write;
      memwb_dest_q   <= exmem_ctrl_q.dest;
      memwb_result_q <= exmem_ctrl_q.mem_read ? Data_BUS_READ : exmem_alu_q;
    end
  end

  // ---------------------------------------------------------------- WB
  assign wb_we   = memwb_we_q;
  assign wb_dest = memwb_dest_q;
  assign wb_data = memwb_result_q;

endmodule

// File: tb/tb_mips_cpu.sv
// Directed bench for mips_cpu: small programs in a bench-side instruction
// memory, expected data-bus transactions queued up front and compared as the
// core issues them.
module tb_mips_cpu;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Prog_BUS_READ;
  logic [31:0] ADDR_Prog;
  logic        CS_P;
  logic [31:0] Data_BUS_READ;
  logic [31:0] ADDR;
  logic [31:0] Data_BUS_WRITE;
  logic        CS;
  logic        WE;

  mips_cpu dut (
    .CLK            (CLK),
    .reset          (reset),
    .Prog_BUS_READ  (Prog_BUS_READ),
    .ADDR_Prog      (ADDR_Prog),
    .CS_P           (CS_P),
    .Data_BUS_READ  (Data_BUS_READ),
    .ADDR           (ADDR),
    .Data_BUS_WRITE (Data_BUS_WRITE),
    .CS             (CS),
    .WE             (WE)
  );

  always #5 CLK = ~CLK;

  logic [31:0] imem [64];
  logic [31:0] fill_word;
  int          wr_ptr;

  assign Prog_BUS_READ = (ADDR_Prog < 32'd64) ? imem[ADDR_Prog[5:0]] : fill_word;
  // Load data only valid during a read cycle; anything else is poison.
  assign Data_BUS_READ = (CS && !WE) ? 32'h0000_22B4 : 32'hBAD0_0000;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  bus_t exp_q[$];
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_checks = 0;
  bit   mon_en = 1'b0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, rs[4:0], rt[4:0], imm};
  endfunction

  task automatic clear_prog(input logic [31:0] w);
    for (int i = 0; i < 64; i++) imem[i] = w;
    fill_word = w;
    wr_ptr    = 0;
    exp_q.delete();
  endtask

  task automatic emit(input logic [31:0] w);
    imem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) emit(32'h0);
  endtask

  task automatic expect_bus(input logic we, input logic [31:0] addr, input logic [31:0] data);
    bus_t e;
    e.we   = we;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic start_run();
    mon_en = 1'b0;
    reset  = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic run_and_drain(input string tag, input int cycles);
    repeat (cycles) @(negedge CLK);
    check32(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: every data-bus cycle must match the next queued expectation.
  always @(negedge CLK) begin
    bus_t e;
    if (mon_en && !reset) begin
      if (WE) check32("we_implies_cs", {31'b0, CS}, 32'd1);
      if (CS) begin
        if (exp_q.size() == 0) begin
          check32("unexpected_bus_cycle", {30'b0, WE, CS}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check32("bus_we", {31'b0, WE}, {31'b0, e.we});
          check32("bus_addr", ADDR, e.addr);
          if (e.we) check32("bus_wdata", Data_BUS_WRITE, e.data);
        end
      end
    end
  end

  initial begin
    bit found;

    // Reset and idle with an unsupported R-type funct everywhere.
    clear_prog(32'h0000_064F);
    reset = 1'b1;
    #100;
    check32("rst_cs_p", {31'b0, CS_P}, 32'd0);
    check32("rst_addr_prog", ADDR_Prog, 32'd0);
    check32("rst_cs_we", {30'b0, CS, WE}, 32'd0);
    check32("rst_addr", ADDR, 32'd0);
    check32("rst_wdata", Data_BUS_WRITE, 32'd0);
    @(negedge CLK);
    reset  = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check32("idle_cs_p", {31'b0, CS_P}, 32'd1);
      check32("idle_pc", ADDR_Prog, 32'(i));
      check32("idle_cs_we", {30'b0, CS, WE}, 32'd0);
    end

    // ADDI then SW after three NOPs.
    clear_prog(32'h0);
    emit(itype(6'h08, 0, 1, 16'd5));
    nops(3);
    emit(itype(6'h2B, 0, 1, 16'd8));
    expect_bus(1'b1, 32'd8, 32'd5);
    start_run();
    run_and_drain("addi_sw_drained", 15);

    // LW followed by SW of the loaded value.
    clear_prog(32'h0);
    emit(itype(6'h23, 0, 2, 16'd4));
    expect_bus(1'b0, 32'd4, 32'h0);
    nops(3);
    emit(itype(6'h2B, 0, 2, 16'd0));
    expect_bus(1'b1, 32'd0, 32'h0000_22B4);
    start_run();
    run_and_drain("lw_drained", 15);

    // ALU operations with r1=7, r3=-2.
    clear_prog(32'h0);
    emit(itype(6'h08, 0, 1, 16'd7));
    emit(itype(6'h08, 0, 3, 16'hFFFE));
    nops(3);
    emit(rtype(1, 3, 4, 6'h22));   // SUB r4 = 9
    emit(rtype(1, 3, 5, 6'h24));   // AND r5 = 6
    emit(rtype(1, 3, 6, 6'h25));   // OR  r6 = -1
    emit(rtype(1, 3, 7, 6'h2A));   // SLT r7 = 0
    emit(rtype(1, 3, 8, 6'h20));   // ADD r8 = 5
    emit(rtype(3, 1, 9, 6'h2A));   // SLT r9 = 1
    nops(3);
    for (int r = 4; r <= 9; r++) emit(itype(6'h2B, 0, r, 16'((r - 4) * 4)));
    expect_bus(1'b1, 32'd0,  32'd9);
    expect_bus(1'b1, 32'd4,  32'd6);
    expect_bus(1'b1, 32'd8,  32'hFFFF_FFFF);
    expect_bus(1'b1, 32'd12, 32'd0);
    expect_bus(1'b1, 32'd16, 32'd5);
    expect_bus(1'b1, 32'd20, 32'd1);
    start_run();
    run_and_drain("alu_drained", 30);

    // r0 stays zero; a too-close consumer sees the stale value.
    clear_prog(32'h0);
    emit(itype(6'h08, 0, 1, 16'd11));
    nops(3);
    emit(itype(6'h08, 0, 0, 16'd9));
    nops(3);
    emit(itype(6'h2B, 0, 0, 16'd0));
    emit(itype(6'h08, 0, 1, 16'd3));
    emit(itype(6'h2B, 0, 1, 16'd4));
    nops(3);
    emit(itype(6'h2B, 0, 1, 16'd12));
    expect_bus(1'b1, 32'd0,  32'd0);
    expect_bus(1'b1, 32'd4,  32'd11);
    expect_bus(1'b1, 32'd12, 32'd3);
    start_run();
    run_and_drain("hazard_drained", 25);

    // Asynchronous reset in the middle of a store.
    clear_prog(32'h0);
    emit(itype(6'h08, 0, 1, 16'd5));
    nops(3);
    emit(itype(6'h2B, 0, 1, 16'd8));
    expect_bus(1'b1, 32'd8, 32'd5);
    start_run();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK);
      if (CS && WE) found = 1'b1;
    end
    check32("store_seen", {31'b0, found}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check32("async_cs", {31'b0, CS}, 32'd0);
    check32("async_we", {31'b0, WE}, 32'd0);
    check32("async_cs_p", {31'b0, CS_P}, 32'd0);
    check32("async_addr_prog", ADDR_Prog, 32'd0);
    check32("async_addr", ADDR, 32'd0);
    mon_en = 1'b0;
    @(negedge CLK);
    check32("held_cs_we", {30'b0, CS, WE}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
